// File: rtl/mwrite_if.sv
// mwrite_if: MMU write channel; mwrite is the master, the memory side is the slave.
interface mwrite_if;
    logic        DATA_WREN;
    logic [31:0] DATA_WADDR;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WDATA;
    logic        DATA_WREADY;
    modport master(output DATA_WREN, DATA_WADDR, DATA_WSTRB, DATA_WDATA, input DATA_WREADY);
    modport slave(input DATA_WREN, DATA_WADDR, DATA_WSTRB, DATA_WDATA, output DATA_WREADY);
endinterface

// File: rtl/mwrite.sv
// mwrite: memory-write stage; issues lane-aligned stores to the MMU and forwards reg/CSR/jump results.
// Optional MWRITE_ALIGN_CHECK_EN raises a store-misaligned exception instead of issuing overflowing strobes.
module mwrite (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        MEM_WAIT,
    input  logic [4:0]  MEMR_REG_W_RD,
    input  logic [31:0] MEMR_REG_W_DATA,
    input  logic        MEMR_CSR_W_EN,
    input  logic [11:0] MEMR_CSR_W_ADDR,
    input  logic [31:0] MEMR_CSR_W_DATA,
    input  logic        MEMR_MEM_W_EN,
    input  logic [3:0]  MEMR_MEM_W_STRB,
    input  logic [31:0] MEMR_MEM_W_ADDR,
    input  logic [31:0] MEMR_MEM_W_DATA,
    input  logic        MEMR_JMP_DO,
    input  logic [31:0] MEMR_JMP_PC,
    mwrite_if.master    dw,
    output logic        MEMW_STALL,
    output logic [4:0]  MEMW_REG_W_RD,
    output logic [31:0] MEMW_REG_W_DATA,
    output logic        MEMW_CSR_W_EN,
    output logic [11:0] MEMW_CSR_W_ADDR,
    output logic [31:0] MEMW_CSR_W_DATA,
    output logic        MEMW_JMP_DO,
    output logic [31:0] MEMW_JMP_PC,
    output logic        MEMW_EXC_EN,
    output logic [3:0]  MEMW_EXC_CODE
);
    typedef enum logic {IDLE, WRITE} state_t;
    state_t      state;
    logic [31:0] waddr, wdata, reg_data, csr_data, jmp_pc;
    logic [11:0] csr_addr;
    logic [4:0]  rd;
    logic [3:0]  wstrb;
    logic        csr_en, jmp_do, exc_en, mis, cap, ld, store, wr;
`ifdef MWRITE_ALIGN_CHECK_EN
    assign mis = MEMR_MEM_W_EN && ((8'(MEMR_MEM_W_STRB) << MEMR_MEM_W_ADDR[1:0]) > 8'd15);
`else
    assign mis = 1'b0;
`endif
    assign wr = state == WRITE;
    assign MEMW_STALL = wr && !dw.DATA_WREADY;
    assign cap = !MEM_WAIT && !MEMW_STALL;
    assign ld = cap && !FLUSH;
    assign store = ld && MEMR_MEM_W_EN && !mis;
    always_ff @(posedge CLK)
        if (RST) begin
            state <= IDLE;
            {waddr, wdata, wstrb} <= '0;
            {rd, reg_data, csr_en, csr_addr, csr_data, jmp_do, jmp_pc, exc_en} <= '0;
        end else begin
            // a pending transfer is never aborted by FLUSH or MEM_WAIT; only READY ends it
            if (store) begin
                state <= WRITE;
                waddr <= {MEMR_MEM_W_ADDR[31:2], 2'b00};
                wstrb <= MEMR_MEM_W_STRB << MEMR_MEM_W_ADDR[1:0];
                wdata <= MEMR_MEM_W_DATA << {MEMR_MEM_W_ADDR[1:0], 3'b000};
            end else if (wr && dw.DATA_WREADY) state <= IDLE;
            if (cap || FLUSH) begin
                rd       <= ld && !mis ? MEMR_REG_W_RD : '0;
                reg_data <= ld ? MEMR_REG_W_DATA : '0;
                csr_en   <= ld && !mis && MEMR_CSR_W_EN;
                csr_addr <= ld ? MEMR_CSR_W_ADDR : '0;
                csr_data <= ld ? MEMR_CSR_W_DATA : '0;
                jmp_do   <= ld && !mis && MEMR_JMP_DO;
                jmp_pc   <= ld ? MEMR_JMP_PC : '0;
                exc_en   <= ld && mis;
            end
        end
    assign dw.DATA_WREN  = wr;
    assign dw.DATA_WADDR = wr ? waddr : '0;
    assign dw.DATA_WSTRB = wr ? wstrb : '0;
    assign dw.DATA_WDATA = wr ? wdata : '0;
    assign MEMW_REG_W_RD   = MEMW_STALL ? '0 : rd;
    assign MEMW_CSR_W_EN   = !MEMW_STALL && csr_en;
    assign MEMW_JMP_DO     = !MEMW_STALL && jmp_do;
    assign MEMW_EXC_EN     = !MEMW_STALL && exc_en;
    assign MEMW_EXC_CODE   = MEMW_EXC_EN ? 4'd6 : 4'd0;
    assign MEMW_REG_W_DATA = reg_data;
    assign MEMW_CSR_W_ADDR = csr_addr;
    assign MEMW_CSR_W_DATA = csr_data;
    assign MEMW_JMP_PC     = jmp_pc;
endmodule

// File: tb/tb_mwrite.sv
// tb_mwrite: table-driven check of mwrite; each row gives one cycle's inputs and the outputs expected in that cycle.
module tb_mwrite;
    typedef struct {
        logic flush, mwait, wready, men;
        logic [3:0] strb;
        logic [31:0] addr, data;
        logic [4:0] rd;
        logic csr, jmp;
        logic e_wren;
        logic [31:0] e_waddr;
        logic [3:0] e_wstrb;
        logic [31:0] e_wdata;
        logic e_stall;
        logic [4:0] e_rd;
        logic e_csr, e_jmp, e_exc;
    } vec_t;

    logic clk = 0, rst = 1, flush = 0, mwait = 0;
    logic [4:0] rd_i = 0, rd_o;
    logic [31:0] reg_data_i = 0, csr_data_i = 0, addr_i = 0, data_i = 0, pc_i = 0;
    logic [31:0] reg_data_o, csr_data_o, pc_o;
    logic [11:0] csr_addr_i = 12'h305, csr_addr_o;
    logic [3:0] strb_i = 0, exc_code;
    logic csr_en_i = 0, men_i = 0, jmp_i = 0;
    logic stall, csr_en_o, jmp_o, exc_en;
    int n_cmp = 0, n_bad = 0;
    vec_t tv[$];

    mwrite_if wif();

    mwrite dut (
        .CLK(clk), .RST(rst), .FLUSH(flush), .MEM_WAIT(mwait),
        .MEMR_REG_W_RD(rd_i), .MEMR_REG_W_DATA(reg_data_i),
        .MEMR_CSR_W_EN(csr_en_i), .MEMR_CSR_W_ADDR(csr_addr_i), .MEMR_CSR_W_DATA(csr_data_i),
        .MEMR_MEM_W_EN(men_i), .MEMR_MEM_W_STRB(strb_i), .MEMR_MEM_W_ADDR(addr_i), .MEMR_MEM_W_DATA(data_i),
        .MEMR_JMP_DO(jmp_i), .MEMR_JMP_PC(pc_i),
        .dw(wif),
        .MEMW_STALL(stall), .MEMW_REG_W_RD(rd_o), .MEMW_REG_W_DATA(reg_data_o),
        .MEMW_CSR_W_EN(csr_en_o), .MEMW_CSR_W_ADDR(csr_addr_o), .MEMW_CSR_W_DATA(csr_data_o),
        .MEMW_JMP_DO(jmp_o), .MEMW_JMP_PC(pc_o), .MEMW_EXC_EN(exc_en), .MEMW_EXC_CODE(exc_code)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic flush, mwait, wready, men, input logic [3:0] strb, input logic [31:0] addr, data,
        input logic [4:0] rd, input logic csr, jmp,
        input logic e_wren, input logic [31:0] e_waddr, input logic [3:0] e_wstrb, input logic [31:0] e_wdata,
        input logic e_stall, input logic [4:0] e_rd, input logic e_csr, e_jmp, e_exc);
        vec_t t;
        t.flush = flush; t.mwait = mwait; t.wready = wready; t.men = men; t.strb = strb;
        t.addr = addr; t.data = data; t.rd = rd; t.csr = csr; t.jmp = jmp;
        t.e_wren = e_wren; t.e_waddr = e_waddr; t.e_wstrb = e_wstrb; t.e_wdata = e_wdata;
        t.e_stall = e_stall; t.e_rd = e_rd; t.e_csr = e_csr; t.e_jmp = e_jmp; t.e_exc = e_exc;
        return t;
    endfunction

    // bubble input with all outputs expected idle
    function automatic vec_t bz(input logic wready);
        return v(0, 0, wready, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input vec_t t);
        flush = t.flush; mwait = t.mwait; wif.DATA_WREADY = t.wready;
        men_i = t.men; strb_i = t.strb; addr_i = t.addr; data_i = t.data;
        rd_i = t.rd; csr_en_i = t.csr; jmp_i = t.jmp;
        reg_data_i = t.data; csr_data_i = t.data; pc_i = t.addr;
    endtask

    task automatic chk(input string nm, input int i, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, i, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t t, input int i);
        chk("wren", i, 32'(wif.DATA_WREN), 32'(t.e_wren));
        chk("waddr", i, wif.DATA_WADDR, t.e_waddr);
        chk("wstrb", i, 32'(wif.DATA_WSTRB), 32'(t.e_wstrb));
        chk("wdata", i, wif.DATA_WDATA, t.e_wdata);
        chk("stall", i, 32'(stall), 32'(t.e_stall));
        chk("rd", i, 32'(rd_o), 32'(t.e_rd));
        chk("csr_en", i, 32'(csr_en_o), 32'(t.e_csr));
        chk("jmp_do", i, 32'(jmp_o), 32'(t.e_jmp));
        chk("exc_en", i, 32'(exc_en), 32'(t.e_exc));
        chk("exc_code", i, 32'(exc_code), t.e_exc ? 32'd6 : 32'd0);
    endtask

    initial begin
        tv.push_back(bz(0));
        // aligned-up byte store to lane 3, accepted immediately
        tv.push_back(v(0,0,1,1, 4'h1, 32'h1003, 32'hAB, 0,0,0, 0,0,0,0, 0,0,0,0,0));
        tv.push_back(v(0,0,1,0, 0,0,0, 0,0,0, 1, 32'h1000, 4'h8, 32'hAB000000, 0,0,0,0,0));
        tv.push_back(bz(0));
        // word store stalled 3 cycles, next store waiting upstream
        tv.push_back(v(0,0,0,1, 4'hF, 32'h2000, 32'h11223344, 5,0,1, 0,0,0,0, 0,0,0,0,0));
        tv.push_back(v(0,0,0,1, 4'h3, 32'h2006, 32'h5566, 7,0,0, 1, 32'h2000, 4'hF, 32'h11223344, 1,0,0,0,0));
        tv.push_back(v(0,0,0,1, 4'h3, 32'h2006, 32'h5566, 7,0,0, 1, 32'h2000, 4'hF, 32'h11223344, 1,0,0,0,0));
        tv.push_back(v(0,0,0,1, 4'h3, 32'h2006, 32'h5566, 7,0,0, 1, 32'h2000, 4'hF, 32'h11223344, 1,0,0,0,0));
        tv.push_back(v(0,0,1,1, 4'h3, 32'h2006, 32'h5566, 7,0,0, 1, 32'h2000, 4'hF, 32'h11223344, 0,5,0,1,0));
        tv.push_back(v(0,0,1,0, 0,0,0, 0,0,0, 1, 32'h2004, 4'hC, 32'h55660000, 0,7,0,0,0));
        tv.push_back(bz(1));
        // flush while stalled: store survives, CSR write is dropped
        tv.push_back(v(0,0,0,1, 4'h1, 32'h4001, 32'h77, 3,1,0, 0,0,0,0, 0,0,0,0,0));
        tv.push_back(v(1,0,0,0, 0,0,0, 0,0,0, 1, 32'h4000, 4'h2, 32'h7700, 1,0,0,0,0));
        tv.push_back(v(0,0,0,0, 0,0,0, 0,0,0, 1, 32'h4000, 4'h2, 32'h7700, 1,0,0,0,0));
        tv.push_back(v(0,0,1,0, 0,0,0, 0,0,0, 1, 32'h4000, 4'h2, 32'h7700, 0,0,0,0,0));
        tv.push_back(bz(0));
        // halfword store crossing the word boundary
        tv.push_back(v(0,0,1,1, 4'h3, 32'h3003, 32'h1234, 9,0,1, 0,0,0,0, 0,0,0,0,0));
`ifdef MWRITE_ALIGN_CHECK_EN
        tv.push_back(v(0,0,1,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,1));
`else
        tv.push_back(v(0,0,1,0, 0,0,0, 0,0,0, 1, 32'h3000, 4'h8, 32'h34000000, 0,9,0,1,0));
`endif
        tv.push_back(bz(1));
        // store at a flush edge and under MEM_WAIT is not taken
        tv.push_back(v(1,0,1,1, 4'hF, 32'h5000, 32'h99, 4,1,1, 0,0,0,0, 0,0,0,0,0));
        tv.push_back(bz(1));
        tv.push_back(v(0,1,1,1, 4'hF, 32'h6000, 32'h88, 2,0,0, 0,0,0,0, 0,0,0,0,0));
        tv.push_back(bz(1));

        wif.DATA_WREADY = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < tv.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(tv[i]);
            #1 chk_vec(tv[i], i);
        end

        // MEM_WAIT does not hold back an accepted write
        @(negedge clk);
        drive(v(0,0,0,1, 4'hF, 32'h7000, 32'hDEAD, 6,0,0, 0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        drive(bz(0)); mwait = 1;
        #1;
        chk("h1_stall", 0, 32'(stall), 1);
        chk("h1_wren", 0, 32'(wif.DATA_WREN), 1);
        chk("h1_rd_gated", 0, 32'(rd_o), 0);
        chk("h1_reg_data", 0, reg_data_o, 32'hDEAD);
        chk("h1_jmp_pc", 0, pc_o, 32'h7000);
        @(negedge clk);
        wif.DATA_WREADY = 1;
        #1;
        chk("h1_stall", 1, 32'(stall), 0);
        chk("h1_wren", 1, 32'(wif.DATA_WREN), 1);
        @(negedge clk);
        wif.DATA_WREADY = 0;
        #1;
        chk("h1_wren", 2, 32'(wif.DATA_WREN), 0);
        chk("h1_stall", 2, 32'(stall), 0);
        @(negedge clk);
        mwait = 0;

        // reset aborts an in-progress write
        @(negedge clk);
        drive(v(0,0,0,1, 4'hF, 32'h8000, 32'h55, 1,0,0, 0,0,0,0, 0,0,0,0,0));
        @(negedge clk);
        drive(bz(0));
        #1 chk("h2_wren", 0, 32'(wif.DATA_WREN), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("h2_wren", 1, 32'(wif.DATA_WREN), 0);
        chk("h2_stall", 1, 32'(stall), 0);
        chk("h2_waddr", 1, wif.DATA_WADDR, 0);
        chk("h2_reg_data", 1, reg_data_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mwrite.md
MWRITE -- requirements
Module: mwrite

Interface
REQ-001 SHALL have ports: CLK in 1 clock; RST in 1 reset (synchronous, active-high); FLUSH in 1 pipeline flush; MEM_WAIT in 1 external pipeline stall.
REQ-002 SHALL have upstream inputs from the memory-read stage: MEMR_REG_W_RD in 5; MEMR_REG_W_DATA in 32; MEMR_CSR_W_EN in 1; MEMR_CSR_W_ADDR in 12; MEMR_CSR_W_DATA in 32; MEMR_MEM_W_EN in 1; MEMR_MEM_W_STRB in 4; MEMR_MEM_W_ADDR in 32; MEMR_MEM_W_DATA in 32; MEMR_JMP_DO in 1; MEMR_JMP_PC in 32.
REQ-003 SHALL have MMU write channel ports: DATA_WREN out 1 request; DATA_WADDR out 32 word address; DATA_WSTRB out 4 lane strobe; DATA_WDATA out 32 lane-aligned data; DATA_WREADY in 1 accept.
REQ-004 SHALL have downstream ports: MEMW_STALL out 1; MEMW_REG_W_RD out 5; MEMW_REG_W_DATA out 32; MEMW_CSR_W_EN out 1; MEMW_CSR_W_ADDR out 12; MEMW_CSR_W_DATA out 32; MEMW_JMP_DO out 1; MEMW_JMP_PC out 32; MEMW_EXC_EN out 1; MEMW_EXC_CODE out 4.

Function
REQ-005 SHALL implement FSM with states IDLE and WRITE.
REQ-006 SHALL capture all MEMR_* inputs at a clock edge when MEM_WAIT=0 and MEMW_STALL=0; otherwise hold captured values.
REQ-007 SHALL enter WRITE at a capture edge where MEMR_MEM_W_EN=1 (and no misalignment under REQ-017); otherwise enter/stay IDLE.
REQ-008 SHALL, in WRITE, drive DATA_WREN=1, DATA_WADDR={addr[31:2],2'b00}, DATA_WSTRB=strb<<addr[1:0] (4-bit truncated), DATA_WDATA=data<<(8*addr[1:0]); in IDLE drive DATA_WREN=0 and other write outputs 0.
REQ-009 SHALL hold DATA_WREN and all write fields stable until an edge with DATA_WREADY=1; that edge completes the transfer and returns to IDLE unless a new store is captured at the same edge (then remain WRITE with new fields).
REQ-010 SHALL drive MEMW_STALL = (state==WRITE) && !DATA_WREADY, combinationally.
REQ-011 SHALL present register, CSR and jump outputs from captured values one cycle after capture, gated: while MEMW_STALL=1 force MEMW_REG_W_RD=0, MEMW_CSR_W_EN=0, MEMW_JMP_DO=0, MEMW_EXC_EN=0 (side effects commit exactly once, in the non-stalled cycle).
REQ-012 SHALL pass MEMW_REG_W_DATA, MEMW_CSR_W_ADDR/DATA, MEMW_JMP_PC ungated.
REQ-013 SHALL, on FLUSH, clear captured reg/CSR/jump/exception fields at that edge; an in-progress WRITE SHALL NOT be aborted and completes per REQ-009; no new store is captured at a FLUSH edge.
REQ-014 SHALL ignore MEM_WAIT for an in-progress WRITE handshake (transfer proceeds and completes).

Reset
REQ-015 SHALL, on RST edge, force state IDLE and zero every captured field, including aborting any in-progress WRITE.
REQ-016 SHALL present all outputs 0 the cycle after reset, including DATA_WREN=0, MEMW_STALL=0.

Configuration
REQ-017 SHALL, with MWRITE_ALIGN_CHECK_EN defined, treat a captured store as misaligned when (strb<<addr[1:0]) overflows 4 bits (strb=0011 with addr[1:0]=11; strb=1111 with addr[1:0]!=00); misaligned store SHALL not enter WRITE, SHALL assert MEMW_EXC_EN=1, MEMW_EXC_CODE=4'd6 for one committed cycle, and SHALL force MEMW_REG_W_RD=0, MEMW_CSR_W_EN=0, MEMW_JMP_DO=0.
REQ-018 SHALL, without MWRITE_ALIGN_CHECK_EN, tie MEMW_EXC_EN=0, MEMW_EXC_CODE=0, and issue every store with truncated strobe.

Verification
REQ-019 Store strb=0001 addr=0x1003 data=0xAB, DATA_WREADY=1 immediately -> DATA_WADDR=0x1000, DATA_WSTRB=1000, DATA_WDATA=0xAB000000, MEMW_STALL=0, one-cycle WRITE.
REQ-020 Store strb=1111 addr=0x2000 with DATA_WREADY low 3 cycles -> DATA_WREN held 4 cycles, MEMW_STALL=1 for 3, inputs not re-captured, back-to-back next store accepted on READY edge.
REQ-021 Capture REG_W_RD=5, JMP_DO=1 during stalled WRITE -> MEMW_REG_W_RD=0, MEMW_JMP_DO=0 while stalled; rd=5, JMP_DO=1 exactly one cycle when READY.
REQ-022 FLUSH during WRITE with READY delayed 2 cycles -> write completes with original fields; captured CSR_W_EN=1 suppressed; RST during WRITE -> DATA_WREN=0 next cycle.
REQ-023 With MWRITE_ALIGN_CHECK_EN: strb=0011 addr=0x3003 -> DATA_WREN never asserted, MEMW_EXC_EN=1, MEMW_EXC_CODE=6 one cycle; without: DATA_WSTRB=1000 issued.
